// File: rtl/lii_pkg.sv
// Shared types and helpers for the LII dispatcher and arbiter blocks.
package lii_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } disp_state_e;

    // Pointer width for an N-entry index, never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lii_rr_dispatch_if.sv
// Upstream/downstream handshake bundle for lii_rr_dispatch.
interface lii_rr_dispatch_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
);
    import lii_pkg::*;

    localparam int unsigned PW = ptr_w(N);

    logic          s_valid;
    logic [W-1:0]  s_data;
    logic          s_ready;
    logic [N-1:0]  m_valid;
    logic [W-1:0]  m_data;
    logic [N-1:0]  m_ready;
    logic [PW-1:0] tgt;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, tgt
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, tgt
    );

endinterface

// File: rtl/lii_rr_ptr.sv
// Modulo-N pointer that steps by one when adv_i is high.
module lii_rr_ptr
    import lii_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adv_i,
    output logic [ptr_w(N)-1:0]       ptr_o
);

    localparam int unsigned PW = ptr_w(N);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/lii_rr_dispatch.sv
// One-word buffer dispatching each word to downstream ports in round-robin order.
// Optional stall retarget enabled by defining LII_RR_DISPATCH_RETARGET_EN.
module lii_rr_dispatch
    import lii_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 32,
    parameter int unsigned TMO = 15
) (
    input  logic               clk,
    input  logic               rst,
    lii_rr_dispatch_if.slave   bus
);

    localparam int unsigned PW = ptr_w(N);

    disp_state_e   state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [PW-1:0] tgt_q;
    logic [N-1:0]  m_vld;
    logic          fire;
    logic          s_rdy;
    logic          s_xfer;
    logic          retarget;

    // Valid is decoded only from registered state, never from m_ready.
    assign m_vld  = (state_q == FULL) ? (N'(1) << tgt_q) : '0;
    assign fire   = |(m_vld & bus.m_ready);
    assign s_rdy  = !rst && ((state_q == EMPTY) || fire);
    assign s_xfer = bus.s_valid && s_rdy;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (s_xfer) begin
            state_d = FULL;
            data_d  = bus.s_data;
        end else if (fire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef LII_RR_DISPATCH_RETARGET_EN
    localparam int unsigned CW = ptr_w(TMO);

    logic [CW-1:0] stall_q, stall_d;

    // The TMO-th consecutive stalled cycle moves the word on; a fire in that cycle wins.
    always_comb begin
        retarget = 1'b0;
        stall_d  = stall_q + CW'(1);
        if ((state_q != FULL) || fire) begin
            stall_d = '0;
        end else if (stall_q == CW'(TMO - 1)) begin
            retarget = 1'b1;
            stall_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign retarget = 1'b0;

    // TMO only matters when stall retarget is compiled in.
    if (TMO == 0) begin : g_tmo_ignored
    end
`endif

    lii_rr_ptr #(.N(N)) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (fire || retarget),
        .ptr_o (tgt_q)
    );

    assign bus.s_ready = s_rdy;
    assign bus.m_valid = m_vld;
    assign bus.m_data  = data_q;
    assign bus.tgt     = tgt_q;

endmodule

// File: tb/tb_lii_rr_dispatch.sv
// Scoreboard bench for lii_rr_dispatch (N=4 directed, N=1 randomized pipeline).
module tb_lii_rr_dispatch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lii_rr_dispatch_if #(.N(4), .W(32)) bus ();
    lii_rr_dispatch_if #(.N(1), .W(8))  bus1 ();

    lii_rr_dispatch #(.N(4), .W(32), .TMO(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lii_rr_dispatch #(.N(1), .W(8), .TMO(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;
    int n1_in  = 0;
    int n1_out = 0;

    logic [35:0] exp_q[$];
    logic [7:0]  exp1_q[$];
    logic [35:0] head;
    logic [7:0]  head1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // N=4 monitor: every downstream fire must match the oldest expected {port, word}.
    always @(negedge clk) begin
        if (!rst && |(bus.m_valid & bus.m_ready)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dispatch", 64'({bus.m_valid, bus.m_data}), 64'h0);
            end else begin
                head = exp_q.pop_front();
                chk("dispatch", 64'({bus.m_valid, bus.m_data}), 64'(head));
            end
        end
    end

    // N=1 monitor: words must leave in acceptance order, on port 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.s_valid && bus1.s_ready) begin
                exp1_q.push_back(bus1.s_data);
                n1_in++;
            end
            if (|(bus1.m_valid & bus1.m_ready)) begin
                n1_out++;
                if (exp1_q.size() == 0) begin
                    chk("n1_unexpected", 64'({1'b1, bus1.m_data}), 64'h0);
                end else begin
                    head1 = exp1_q.pop_front();
                    chk("n1_dispatch", 64'({bus1.tgt, bus1.m_data}), 64'({1'b0, head1}));
                end
            end
        end
    end

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.m_ready  = '0;
        bus1.s_valid = 1'b0;
        bus1.s_data  = '0;
        bus1.m_ready = '0;

        @(posedge clk);
        @(negedge clk);
        chk("reset_m_valid", 64'(bus.m_valid), 64'h0);
        chk("reset_tgt",     64'(bus.tgt),     64'h0);
        chk("reset_m_data",  64'(bus.m_data),  64'h0);
        chk("reset_s_ready", 64'(bus.s_ready), 64'h0);
        step();
        rst = 1'b0;

        // Back-to-back stream with all ports ready: ports 0,1,2,3,0,1,2,3.
        bus.m_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(32'hA0 + i);
            exp_q.push_back({4'(4'b0001 << (i % 4)), 32'(32'hA0 + i)});
            @(negedge clk);
            chk("s_ready_stream", 64'(bus.s_ready), 64'h1);
            step();
        end
        bus.s_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("tgt_after_wrap", 64'(bus.tgt),     64'h0);
        chk("idle_m_valid",   64'(bus.m_valid), 64'h0);
        step();

`ifndef LII_RR_DISPATCH_RETARGET_EN
        // Stalled word holds its port indefinitely.
        bus.m_ready = '0;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h11;
        exp_q.push_back({4'b0001, 32'h11});
        step();
        bus.s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold", 64'({bus.m_valid, bus.m_data, bus.s_ready, bus.tgt}),
                64'({4'b0001, 32'h11, 1'b0, 2'd0}));
        end
        step();
        bus.m_ready = 4'b0001;
        step();
        bus.m_ready = '0;
        @(negedge clk);
        chk("stall_release_tgt", 64'(bus.tgt), 64'h1);
        step();
`endif

        // Reset while holding 0x55 must drop it.
        bus.m_ready = '0;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h55;
        step();
        bus.s_valid = 1'b0;
        @(negedge clk);
`ifdef LII_RR_DISPATCH_RETARGET_EN
        chk("pre_reset_m_valid", 64'(bus.m_valid), 64'h1);
`else
        chk("pre_reset_m_valid", 64'(bus.m_valid), 64'h2);
`endif
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_m_valid", 64'(bus.m_valid), 64'h0);
        chk("post_reset_tgt",     64'(bus.tgt),     64'h0);
        bus.m_ready = 4'hF;
        repeat (5) step();

`ifdef LII_RR_DISPATCH_RETARGET_EN
        // Port 0 never ready: after 3 stalled cycles the word moves to port 1.
        do_reset();
        bus.m_ready = 4'b0010;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h33;
        exp_q.push_back({4'b0010, 32'h33});
        step();
        bus.s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tmo_hold_port0", 64'(bus.m_valid), 64'h1);
        end
        @(negedge clk);
        chk("tmo_moved_port1", 64'(bus.m_valid), 64'h2);
        step();
        @(negedge clk);
        chk("tmo_next_tgt", 64'(bus.tgt), 64'h2);

        // Ready arriving in the timeout cycle beats the retarget.
        do_reset();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h34;
        exp_q.push_back({4'b0001, 32'h34});
        step();
        bus.s_valid = 1'b0;
        step();
        step();
        bus.m_ready = 4'b0001;
        step();
        bus.m_ready = '0;
        @(negedge clk);
        chk("tmo_edge_tgt",     64'(bus.tgt),     64'h1);
        chk("tmo_edge_m_valid", 64'(bus.m_valid), 64'h0);
        step();
`endif

        // N=1 pipeline under random valid/ready.
        for (int i = 0; i < 300; i++) begin
            bus1.s_valid = 1'($urandom_range(0, 1));
            bus1.s_data  = 8'($urandom);
            bus1.m_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus1.s_valid = 1'b0;
        bus1.m_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("n1_count",     64'(n1_out),          64'(n1_in));
        chk("n1_drained",   64'(exp1_q.size()),   64'h0);
        chk("n4_drained",   64'(exp_q.size()),    64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
